// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_pkg;

  // Occupancy of a stage register. SKIDDED only exists with the skid buffer enabled.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } pipe_state_t;

  // NOP control bit; replicated to any bundle width, an all-zero bundle writes nothing.
  localparam logic CTRL_NOP = 1'b0;

  // ID/EX control bundle.
  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic       link;
  } idex_ctrl_t;

  // EX/MEM control bundle.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } exmem_ctrl_t;

  // MEM/WB control bundle.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, updated on the falling clock edge.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_value
);

  localparam logic [W-1:0] LP_ONE = W'(1);

  logic [W-1:0] r_value;

  // Count enabled edges, holding at all-ones.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_inc && (r_value != '1)) begin
      r_value <= r_value + LP_ONE;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and stall/bubble performance counters. State updates on negedge.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 192,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CTRL_W-1:0] LP_NOP = {CTRL_W{CTRL_NOP}};

  pipe_state_t       r_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_out_valid;
  logic w_accept;
  logic w_consume;

  assign w_out_valid = (r_state != EMPTY);
  // Without the skid entry, ready must look through to the downstream consumer.
  assign in_ready    = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = w_out_valid && out_ready;

  // Occupancy FSM and entry storage; flush squashes validity and control only.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= LP_NOP;
      r_skid_ctrl <= LP_NOP;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state     <= FULL;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
        FULL: begin
          if (w_accept && w_consume) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            // Only reachable with the skid entry; single-entry ready blocks this case.
            r_state     <= SKIDDED;
            r_in_ready  <= 1'b0;
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end else if (w_consume) begin
            r_state <= EMPTY;
          end
        end
        SKIDDED: begin
          if (w_consume) begin
            r_state     <= FULL;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : LP_NOP;
  assign out_data  = r_main_data;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_inc   (w_out_valid && !out_ready),
    .o_value (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_inc   (!w_out_valid && out_ready),
    .o_value (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, single-entry mode and a narrow-counter copy.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW = $bits(idex_ctrl_t);
  localparam int unsigned DW = 32;

  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          in_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, bubble_cnt;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [3:0]    c_stall_cnt, c_bubble_cnt;

  logic          b_in_valid, b_out_ready, b_flush;
  logic [CW-1:0] b_in_ctrl;
  logic [DW-1:0] b_in_data;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_stall_cnt, b_bubble_cnt;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .flush(flush), .stall_cnt(c_stall_cnt),
    .bubble_cnt(c_bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data), .flush(b_flush),
    .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active (falling) edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int unsigned c, input int unsigned d);
    in_valid = v;
    in_ctrl  = CW'(c);
    in_data  = DW'(d);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 0, 0);
    out_ready = 1'b0; flush = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
    b_in_ctrl = '0; b_in_data = '0;
    step(); step();

    // Reset state
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_stall", 64'(stall_cnt), 64'd0);
    check_val("rst_bubble", 64'(bubble_cnt), 64'd0);
    reset_n = 1'b1;

    // Bubble counting and saturation on the 4-bit copy
    out_ready = 1'b1;
    repeat (20) step();
    check_val("bub_cnt16", 64'(bubble_cnt), 64'd20);
    check_val("bub_cnt4_sat", 64'(c_bubble_cnt), 64'd15);
    check_val("bub_stall", 64'(stall_cnt), 64'd0);
    reset_n = 1'b0;
    #1;
    check_val("bub_rst_clear", 64'(bubble_cnt), 64'd0);
    reset_n = 1'b1;

    // Full throughput: one per edge, one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 32'h100 * i);
      #1;
      check_val($sformatf("tp_in_ready_%0d", i), 64'(in_ready), 64'd1);
      step();
      check_val($sformatf("tp_valid_%0d", i), 64'(out_valid), 64'd1);
      check_val($sformatf("tp_ctrl_%0d", i), 64'(out_ctrl), 64'(i));
      check_val($sformatf("tp_data_%0d", i), 64'(out_data), 64'(32'h100 * i));
    end
    drive(1'b0, 0, 0);
    step();
    check_val("tp_drain_valid", 64'(out_valid), 64'd0);
    check_val("tp_drain_ctrl", 64'(out_ctrl), 64'd0);
    check_val("tp_stall", 64'(stall_cnt), 64'd0);
    check_val("tp_bubble", 64'(bubble_cnt), 64'd1);

    // Backpressure: one extra accept into the skid entry, then in_ready low
    drive(1'b1, 'hA1, 'hA1);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 'hA2, 'hA2);
      else        drive(1'b1, 'hA3, 'hA3);
      #1;
      check_val($sformatf("bp_in_ready_%0d", k), 64'(in_ready), (k == 0) ? 64'd1 : 64'd0);
      step();
      check_val($sformatf("bp_hold_ctrl_%0d", k), 64'(out_ctrl), 64'hA1);
    end
    check_val("bp_in_ready_after", 64'(in_ready), 64'd0);
    check_val("bp_stall", 64'(stall_cnt), 64'd4);
    drive(1'b0, 0, 0);
    out_ready = 1'b1;
    step();
    check_val("bp_second_valid", 64'(out_valid), 64'd1);
    check_val("bp_second_ctrl", 64'(out_ctrl), 64'hA2);
    check_val("bp_second_data", 64'(out_data), 64'hA2);
    check_val("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    check_val("bp_empty", 64'(out_valid), 64'd0);
    check_val("bp_stall_final", 64'(stall_cnt), 64'd4);
    check_val("bp_bubble", 64'(bubble_cnt), 64'd2);

    // Flush while SKIDDED with in_valid high on the same edge
    out_ready = 1'b0;
    drive(1'b1, 'hB1, 'hB1);
    step();
    drive(1'b1, 'hB2, 'hB2);
    step();
    check_val("fl_skidded_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 'hB3, 'hB3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 0, 0);
    out_ready = 1'b1;
    #1;
    check_val("fl_valid", 64'(out_valid), 64'd0);
    check_val("fl_ctrl", 64'(out_ctrl), 64'd0);
    check_val("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    check_val("fl_nothing_emitted", 64'(out_valid), 64'd0);
    check_val("fl_data_kept", 64'(out_data), 64'hB1);
    // Flush from EMPTY discards a same-edge accept
    drive(1'b1, 'hC5, 'hC5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 0, 0);
    check_val("fl_acc_valid", 64'(out_valid), 64'd0);
    check_val("fl_acc_data", 64'(out_data), 64'hB1);
    step();
    check_val("fl_stall", 64'(stall_cnt), 64'd6);
    check_val("fl_bubble", 64'(bubble_cnt), 64'd5);

    // Reset mid-stream
    out_ready = 1'b1;
    drive(1'b1, 'h11, 'h11); step();
    drive(1'b1, 'h22, 'h22); step();
    drive(1'b1, 'h33, 'h33); step();
    check_val("rm_data_33", 64'(out_data), 64'h33);
    reset_n = 1'b0;
    #1;
    check_val("rm_valid", 64'(out_valid), 64'd0);
    check_val("rm_ctrl", 64'(out_ctrl), 64'd0);
    check_val("rm_data", 64'(out_data), 64'd0);
    check_val("rm_in_ready", 64'(in_ready), 64'd1);
    check_val("rm_stall", 64'(stall_cnt), 64'd0);
    check_val("rm_bubble", 64'(bubble_cnt), 64'd0);
    reset_n = 1'b1;

    // Reset while SKIDDED restores in_ready at once
    out_ready = 1'b0;
    drive(1'b1, 'hD1, 'hD1); step();
    drive(1'b1, 'hD2, 'hD2); step();
    check_val("rs_ready_low", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check_val("rs_ready_high", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    drive(1'b1, 'hE1, 'hE1);
    step();
    check_val("rs_first_accept", 64'(out_ctrl), 64'hE1);
    drive(1'b0, 0, 0);
    out_ready = 1'b1;
    step();

    // Single-entry mode
    b_in_valid = 1'b1; b_in_ctrl = CW'(16'hC1); b_in_data = DW'(32'hC1);
    #1;
    check_val("se_ready_empty", 64'(b_in_ready), 64'd1);
    step();
    check_val("se_valid", 64'(b_out_valid), 64'd1);
    check_val("se_ctrl_c1", 64'(b_out_ctrl), 64'hC1);
    check_val("se_ready_held", 64'(b_in_ready), 64'd0);
    b_in_ctrl = CW'(16'hC2); b_in_data = DW'(32'hC2);
    step();
    check_val("se_hold_c1", 64'(b_out_ctrl), 64'hC1);
    check_val("se_stall", 64'(b_stall_cnt), 64'd1);
    b_out_ready = 1'b1;
    #1;
    check_val("se_ready_comb", 64'(b_in_ready), 64'd1);
    step();
    check_val("se_swap_valid", 64'(b_out_valid), 64'd1);
    check_val("se_swap_ctrl", 64'(b_out_ctrl), 64'hC2);
    check_val("se_swap_data", 64'(b_out_data), 64'hC2);
    b_in_valid = 1'b0;
    step();
    check_val("se_drain_valid", 64'(b_out_valid), 64'd0);
    check_val("se_drain_ctrl", 64'(b_out_ctrl), 64'd0);
    check_val("se_stall_final", 64'(b_stall_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
